// File: rtl/id_imm_ctrl.sv
// id_imm_ctrl: decode-stage 2-entry skid buffer producing immediate-select codes for the sign-extension unit
module id_imm_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic [XLEN-1:0] INSTR_IN,
  input  logic [XLEN-1:0] PC_IN,
  input  logic            VALID_IN,
  output logic            READY_OUT,
  output logic [XLEN-1:0] INSTR_OUT,
  output logic [XLEN-1:0] PC_OUT,
  output logic [2:0]      IMMI_SEL,
  output logic            IMM_USED,
  output logic            ILLEGAL,
  output logic            VALID_OUT,
  input  logic            READY_IN
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      sel;
    logic            used;
    logic            ill;
  } entry_t;
  state_t state, state_n;
  entry_t e0, e1, e0_n, e1_n, dec;
  logic push, pop;
  assign READY_OUT = state != TWO;
  assign VALID_OUT = state != EMPTY;
  assign push = VALID_IN && READY_OUT;
  assign pop = VALID_OUT && READY_IN;
  always_comb begin
    dec = '{instr: INSTR_IN, pc: PC_IN, sel: 3'b111, used: 1'b0, ill: 1'b0};
    case (INSTR_IN[6:0])
      7'b0000011, 7'b1100111: begin dec.sel = 3'b000; dec.used = 1'b1; end
      7'b0010011: begin
        dec.sel = (INSTR_IN[13:12] == 2'b01) ? 3'b001 : 3'b000;
        dec.used = 1'b1;
      end
      7'b0100011, 7'b1100011: begin dec.sel = 3'b010; dec.used = 1'b1; end
      7'b0110111, 7'b0010111: begin dec.sel = 3'b011; dec.used = 1'b1; end
      7'b1101111: begin dec.sel = 3'b100; dec.used = 1'b1; end
      7'b0110011, 7'b0001111, 7'b1110011: dec.ill = 1'b0;
      default: dec.ill = 1'b1;
    endcase
  end
  always_comb begin
    state_n = state;
    e0_n = e0;
    e1_n = e1;
    if (FLUSH) state_n = EMPTY;
    else case (state)
      EMPTY: if (push) begin state_n = ONE; e0_n = dec; end
      ONE: begin
        if (push && pop) e0_n = dec;
        else if (push) begin state_n = TWO; e1_n = dec; end
        else if (pop) state_n = EMPTY;
      end
      TWO: if (pop) begin state_n = ONE; e0_n = e1; end
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= EMPTY;
      e0 <= '0;
      e1 <= '0;
    end else begin
      state <= state_n;
      e0 <= e0_n;
      e1 <= e1_n;
    end
  end
  // empty head presents a neutral "no immediate" pattern
  assign INSTR_OUT = VALID_OUT ? e0.instr : '0;
  assign PC_OUT    = VALID_OUT ? e0.pc : '0;
  assign IMMI_SEL  = VALID_OUT ? e0.sel : 3'b111;
  assign IMM_USED  = VALID_OUT && e0.used;
  assign ILLEGAL   = VALID_OUT && e0.ill;
endmodule

// File: tb/tb_id_imm_ctrl.sv
// tb_id_imm_ctrl: directed self-checking bench for id_imm_ctrl
module tb_id_imm_ctrl;
  logic        CLK = 0, RESET = 0, FLUSH = 0, VALID_IN = 0, READY_IN = 0;
  logic [31:0] INSTR_IN = 0, PC_IN = 0;
  logic        READY_OUT, IMM_USED, ILLEGAL, VALID_OUT;
  logic [31:0] INSTR_OUT, PC_OUT;
  logic [2:0]  IMMI_SEL;
  int pass_cnt = 0, total = 0;

  id_imm_ctrl #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .INSTR_IN(INSTR_IN), .PC_IN(PC_IN),
    .VALID_IN(VALID_IN), .READY_OUT(READY_OUT), .INSTR_OUT(INSTR_OUT), .PC_OUT(PC_OUT),
    .IMMI_SEL(IMMI_SEL), .IMM_USED(IMM_USED), .ILLEGAL(ILLEGAL), .VALID_OUT(VALID_OUT),
    .READY_IN(READY_IN)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] p);
    VALID_IN = 1; INSTR_IN = i; PC_IN = p;
  endtask

  // {VALID_OUT, READY_OUT, IMMI_SEL, IMM_USED, ILLEGAL}
  task automatic test_reset();
    RESET = 1; VALID_IN = 0; READY_IN = 0; FLUSH = 0;
    step();
    RESET = 0;
    total++;
    if ({VALID_OUT, READY_OUT, IMMI_SEL, IMM_USED, ILLEGAL} !== 7'b0111100)
      $display("FAIL reset_ctrl got %b want 0111100", {VALID_OUT, READY_OUT, IMMI_SEL, IMM_USED, ILLEGAL});
    else pass_cnt++;
    total++;
    if ({INSTR_OUT, PC_OUT} !== 64'h0)
      $display("FAIL reset_data got %h want 0", {INSTR_OUT, PC_OUT});
    else pass_cnt++;
  endtask

  task automatic test_addi();
    READY_IN = 1;
    offer(32'hFFF00093, 32'h100);
    step();
    VALID_IN = 0;
    total++;
    if ({VALID_OUT, IMMI_SEL, IMM_USED, ILLEGAL} !== 6'b100010)
      $display("FAIL addi_ctrl got %b want 100010", {VALID_OUT, IMMI_SEL, IMM_USED, ILLEGAL});
    else pass_cnt++;
    total++;
    if ({INSTR_OUT, PC_OUT} !== {32'hFFF00093, 32'h100})
      $display("FAIL addi_data got %h/%h want fff00093/00000100", INSTR_OUT, PC_OUT);
    else pass_cnt++;
    step();
    total++;
    if (VALID_OUT !== 1'b0) $display("FAIL addi_drain got %b want 0", VALID_OUT);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [6] = '{32'h00309093, 32'h0020A223, 32'h00208463, 32'h123450B7, 32'h008000EF, 32'h002081B3};
    logic [2:0]  sel [6] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b111};
    logic        used [6] = '{1, 1, 1, 1, 1, 0};
    READY_IN = 1;
    for (int k = 0; k < 6; k++) begin
      offer(ins[k], 32'h200 + 4 * k);
      step();
      total++;
      if ({VALID_OUT, READY_OUT, INSTR_OUT, PC_OUT, IMMI_SEL, IMM_USED} !== {2'b11, ins[k], 32'h200 + 4 * k, sel[k], used[k]})
        $display("FAIL b2b_%0d got instr %h sel %b used %b v %b r %b want instr %h sel %b used %b v 1 r 1",
                 k, INSTR_OUT, IMMI_SEL, IMM_USED, VALID_OUT, READY_OUT, ins[k], sel[k], used[k]);
      else pass_cnt++;
    end
    VALID_IN = 0;
    step();
    total++;
    if (VALID_OUT !== 1'b0) $display("FAIL b2b_drain got %b want 0", VALID_OUT);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    READY_IN = 0;
    offer(32'h00002083, 32'h300);
    step();
    total++;
    if ({VALID_OUT, READY_OUT, INSTR_OUT} !== {2'b11, 32'h00002083})
      $display("FAIL stall_one got v%b r%b %h want v1 r1 00002083", VALID_OUT, READY_OUT, INSTR_OUT);
    else pass_cnt++;
    offer(32'h00112023, 32'h304);
    step();
    total++;
    if ({VALID_OUT, READY_OUT, INSTR_OUT, IMMI_SEL} !== {2'b10, 32'h00002083, 3'b000})
      $display("FAIL stall_two got v%b r%b %h sel %b want v1 r0 00002083 sel 000", VALID_OUT, READY_OUT, INSTR_OUT, IMMI_SEL);
    else pass_cnt++;
    offer(32'h00000097, 32'h308);
    step();
    total++;
    if ({READY_OUT, INSTR_OUT, PC_OUT} !== {1'b0, 32'h00002083, 32'h300})
      $display("FAIL stall_hold got r%b %h/%h want r0 00002083/00000300", READY_OUT, INSTR_OUT, PC_OUT);
    else pass_cnt++;
    VALID_IN = 0; READY_IN = 1;
    step();
    total++;
    if ({VALID_OUT, READY_OUT, INSTR_OUT, PC_OUT, IMMI_SEL} !== {2'b11, 32'h00112023, 32'h304, 3'b010})
      $display("FAIL stall_pop1 got v%b r%b %h/%h sel %b want v1 r1 00112023/00000304 sel 010",
               VALID_OUT, READY_OUT, INSTR_OUT, PC_OUT, IMMI_SEL);
    else pass_cnt++;
    offer(32'h00000097, 32'h308);
    step();
    VALID_IN = 0;
    total++;
    if ({VALID_OUT, INSTR_OUT, PC_OUT, IMMI_SEL} !== {1'b1, 32'h00000097, 32'h308, 3'b011})
      $display("FAIL stall_pop2 got v%b %h/%h sel %b want v1 00000097/00000308 sel 011", VALID_OUT, INSTR_OUT, PC_OUT, IMMI_SEL);
    else pass_cnt++;
    step();
    total++;
    if (VALID_OUT !== 1'b0) $display("FAIL stall_empty got %b want 0", VALID_OUT);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    READY_IN = 0;
    offer(32'h00000013, 32'h400); step();
    offer(32'h00000033, 32'h404); step();
    total++;
    if (READY_OUT !== 1'b0) $display("FAIL flush_setup got %b want 0", READY_OUT);
    else pass_cnt++;
    FLUSH = 1; offer(32'h0000006F, 32'h408);
    step();
    FLUSH = 0; VALID_IN = 0;
    total++;
    if ({VALID_OUT, READY_OUT, IMMI_SEL, INSTR_OUT} !== {2'b01, 3'b111, 32'h0})
      $display("FAIL flush got v%b r%b sel %b %h want v0 r1 sel 111 0", VALID_OUT, READY_OUT, IMMI_SEL, INSTR_OUT);
    else pass_cnt++;
    step();
    total++;
    if (VALID_OUT !== 1'b0) $display("FAIL flush_discard got %b want 0", VALID_OUT);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    READY_IN = 1;
    offer(32'h0000007F, 32'h500);
    step();
    total++;
    if ({VALID_OUT, IMMI_SEL, IMM_USED, ILLEGAL} !== 6'b111101)
      $display("FAIL illegal got %b want 111101", {VALID_OUT, IMMI_SEL, IMM_USED, ILLEGAL});
    else pass_cnt++;
    offer(32'h0000000F, 32'h504);
    step();
    VALID_IN = 0;
    total++;
    if ({VALID_OUT, IMMI_SEL, IMM_USED, ILLEGAL} !== 6'b111100)
      $display("FAIL fence got %b want 111100", {VALID_OUT, IMMI_SEL, IMM_USED, ILLEGAL});
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    READY_IN = 0;
    offer(32'h00A00513, 32'h600); step();
    offer(32'h00B00593, 32'h604); step();
    VALID_IN = 0; RESET = 1;
    step();
    RESET = 0;
    total++;
    if ({VALID_OUT, READY_OUT, IMMI_SEL, IMM_USED, ILLEGAL, INSTR_OUT, PC_OUT} !== {7'b0111100, 64'h0})
      $display("FAIL reset_mid got v%b r%b sel %b u%b i%b %h/%h want v0 r1 sel 111 u0 i0 0/0",
               VALID_OUT, READY_OUT, IMMI_SEL, IMM_USED, ILLEGAL, INSTR_OUT, PC_OUT);
    else pass_cnt++;
    READY_IN = 1;
    step();
    total++;
    if (VALID_OUT !== 1'b0) $display("FAIL reset_mid_after got %b want 0", VALID_OUT);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
